// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch predictor: default table geometry,
// 2-bit saturating counter encodings, performance counter ceiling and the
// counter update rule used by the table.
// -----------------------------------------------------------------------------
package bp_pkg;

   localparam int BP_INDEX_BITS = 4;   // log2 of table entries
   localparam int BP_TAG_BITS   = 8;   // stored PC tag width

   // 2-bit direction counter states
   localparam logic [1:0] CTR_SNT = 2'b00;  // strongly not-taken
   localparam logic [1:0] CTR_WNT = 2'b01;  // weakly not-taken (reset state)
   localparam logic [1:0] CTR_WT  = 2'b10;  // weakly taken (fresh allocation)
   localparam logic [1:0] CTR_ST  = 2'b11;  // strongly taken

   localparam logic [15:0] PERF_MAX = 16'hFFFF;

   // Saturating step of a direction counter towards the resolved outcome.
   function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      nxt = ctr;
      if (taken) begin
         if (ctr != CTR_ST) nxt = ctr + 2'd1;
      end else begin
         if (ctr != CTR_SNT) nxt = ctr - 2'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/bp_table.sv
// -----------------------------------------------------------------------------
// bp_table
// Direct-mapped predictor storage. Each entry holds valid, tag, 2-bit counter
// and 32-bit target. One asynchronous read port (fetch lookup) and one
// synchronous update port (decode resolution). The update port performs its
// own read-modify-write: a tag hit steps the counter (and refreshes the target
// when taken), a taken miss allocates the entry, a not-taken miss is dropped.
// Reads return pre-update contents; there is no write-to-read bypass.
//
// Ports
//   clk, reset         : clock, synchronous active-high reset (valid/counters)
//   i_rd_index         : fetch lookup index
//   o_rd_valid/tag/ctr/target : entry contents at i_rd_index
//   i_wr_en            : perform an update this cycle
//   i_wr_index/tag     : decode-stage index and tag of the resolved branch
//   i_wr_taken         : resolved direction
//   i_wr_target        : resolved target
// -----------------------------------------------------------------------------
module bp_table
   import bp_pkg::*;
#(
   parameter int INDEX_BITS = BP_INDEX_BITS,
   parameter int TAG_BITS   = BP_TAG_BITS
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [INDEX_BITS-1:0] i_rd_index,
   output logic                  o_rd_valid,
   output logic [TAG_BITS-1:0]   o_rd_tag,
   output logic [1:0]            o_rd_ctr,
   output logic [31:0]           o_rd_target,
   input  logic                  i_wr_en,
   input  logic [INDEX_BITS-1:0] i_wr_index,
   input  logic [TAG_BITS-1:0]   i_wr_tag,
   input  logic                  i_wr_taken,
   input  logic [31:0]           i_wr_target
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   logic                r_valid  [ENTRIES];
   logic [TAG_BITS-1:0] r_tag    [ENTRIES];
   logic [1:0]          r_ctr    [ENTRIES];
   logic [31:0]         r_target [ENTRIES];

   logic w_wr_hit;

   assign o_rd_valid  = r_valid[i_rd_index];
   assign o_rd_tag    = r_tag[i_rd_index];
   assign o_rd_ctr    = r_ctr[i_rd_index];
   assign o_rd_target = r_target[i_rd_index];

   // Hit is re-evaluated against current contents at update time, so an entry
   // replaced by an alias between fetch and decode is treated as a miss.
   assign w_wr_hit = r_valid[i_wr_index] & (r_tag[i_wr_index] == i_wr_tag);

   // Valid bits and counters: reset-cleared control state.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i] <= 1'b0;
            r_ctr[i]   <= CTR_WNT;
         end
      end else if (i_wr_en) begin
         if (w_wr_hit) begin
            r_ctr[i_wr_index] <= ctr_next(r_ctr[i_wr_index], i_wr_taken);
         end else if (i_wr_taken) begin
            r_valid[i_wr_index] <= 1'b1;
            r_ctr[i_wr_index]   <= CTR_WT;
         end
      end
   end

   // Tags and targets are plain storage; they are only meaningful when valid,
   // so they carry no reset, but reset still blocks any same-cycle write.
   always_ff @(posedge clk) begin
      if (!reset && i_wr_en) begin
         if (i_wr_taken) begin
            r_target[i_wr_index] <= i_wr_target;
         end
         if (!w_wr_hit && i_wr_taken) begin
            r_tag[i_wr_index] <= i_wr_tag;
         end
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Tagged, direct-mapped branch predictor with 2-bit counters and a target
// table. Fetch lookup is combinational; the prediction travels to decode in an
// F->D register, where it is compared against the resolved branch to flag a
// mispredict and to train the table. Two saturating performance counters
// track updates and mispredicted updates.
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   PCF             : fetch PC
//   StallF          : fetch stall (prediction stays combinational; unused)
//   StallD, FlushD  : hold / clear the F->D prediction register (flush wins)
//   BranchD         : valid branch in decode
//   BranchTakenD    : resolved direction
//   BranchTargetD   : resolved target
//   PredictTakenF   : fetch redirect request
//   PredictTargetF  : predicted next PC
//   Prediction      : registered prediction of the decode instruction
//   MispredictD     : direction or target mismatch in decode
//   BranchCount     : number of table updates (saturating)
//   MispredictCount : number of mispredicted updates (saturating)
// -----------------------------------------------------------------------------
module branch_predictor
   import bp_pkg::*;
#(
   parameter int INDEX_BITS = BP_INDEX_BITS,
   parameter int TAG_BITS   = BP_TAG_BITS
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PCF,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic        BranchD,
   input  logic        BranchTakenD,
   input  logic [31:0] BranchTargetD,
   output logic        PredictTakenF,
   output logic [31:0] PredictTargetF,
   output logic        Prediction,
   output logic        MispredictD,
   output logic [15:0] BranchCount,
   output logic [15:0] MispredictCount
);

   logic [INDEX_BITS-1:0] w_f_index;
   logic [TAG_BITS-1:0]   w_f_tag;
   logic                  w_rd_valid;
   logic [TAG_BITS-1:0]   w_rd_tag;
   logic [1:0]            w_rd_ctr;
   logic [31:0]           w_rd_target;
   logic                  w_hit;
   logic                  w_update;
   logic                  w_unused;

   logic                  r_prediction;
   logic [31:0]           r_pred_target;
   logic [INDEX_BITS-1:0] r_d_index;
   logic [TAG_BITS-1:0]   r_d_tag;
   logic [15:0]           r_branch_cnt;
   logic [15:0]           r_mispredict_cnt;

   // Fetch stall does not gate the lookup; fetch simply re-presents its PC.
   assign w_unused = StallF;

   assign w_f_index = PCF[INDEX_BITS+1:2];
   assign w_f_tag   = PCF[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];

   bp_table #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TAG_BITS)
   ) u_table (
      .clk         (clk),
      .reset       (reset),
      .i_rd_index  (w_f_index),
      .o_rd_valid  (w_rd_valid),
      .o_rd_tag    (w_rd_tag),
      .o_rd_ctr    (w_rd_ctr),
      .o_rd_target (w_rd_target),
      .i_wr_en     (w_update),
      .i_wr_index  (r_d_index),
      .i_wr_tag    (r_d_tag),
      .i_wr_taken  (BranchTakenD),
      .i_wr_target (BranchTargetD)
   );

   assign w_hit          = w_rd_valid & (w_rd_tag == w_f_tag);
   assign PredictTakenF  = w_hit & w_rd_ctr[1];
   assign PredictTargetF = PredictTakenF ? w_rd_target : (PCF + 32'd4);

   // A stalled decode instruction is re-presented next cycle, so it trains
   // the table only once, on the cycle it leaves decode.
   assign w_update = BranchD & ~StallD;

   // Taken-vs-taken with a different target is still a mispredict.
   assign MispredictD = BranchD & ((BranchTakenD ^ r_prediction) |
                        (r_prediction & BranchTakenD & (r_pred_target != BranchTargetD)));

   // F->D prediction register: flush beats stall.
   always_ff @(posedge clk) begin
      if (reset || FlushD) begin
         r_prediction  <= 1'b0;
         r_pred_target <= '0;
         r_d_index     <= '0;
         r_d_tag       <= '0;
      end else if (!StallD) begin
         r_prediction  <= PredictTakenF;
         r_pred_target <= PredictTargetF;
         r_d_index     <= w_f_index;
         r_d_tag       <= w_f_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_branch_cnt     <= '0;
         r_mispredict_cnt <= '0;
      end else if (w_update) begin
         if (r_branch_cnt != PERF_MAX) r_branch_cnt <= r_branch_cnt + 16'd1;
         if (MispredictD && (r_mispredict_cnt != PERF_MAX)) begin
            r_mispredict_cnt <= r_mispredict_cnt + 16'd1;
         end
      end
   end

   assign Prediction      = r_prediction;
   assign BranchCount     = r_branch_cnt;
   assign MispredictCount = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] PCF;
   logic        StallF;
   logic        StallD;
   logic        FlushD;
   logic        BranchD;
   logic        BranchTakenD;
   logic [31:0] BranchTargetD;
   logic        PredictTakenF;
   logic [31:0] PredictTargetF;
   logic        Prediction;
   logic        MispredictD;
   logic [15:0] BranchCount;
   logic [15:0] MispredictCount;

   int n_checks = 0;
   int n_errors = 0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   branch_predictor #(
      .INDEX_BITS (4),
      .TAG_BITS   (8)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .PCF             (PCF),
      .StallF          (StallF),
      .StallD          (StallD),
      .FlushD          (FlushD),
      .BranchD         (BranchD),
      .BranchTakenD    (BranchTakenD),
      .BranchTargetD   (BranchTargetD),
      .PredictTakenF   (PredictTakenF),
      .PredictTargetF  (PredictTargetF),
      .Prediction      (Prediction),
      .MispredictD     (MispredictD),
      .BranchCount     (BranchCount),
      .MispredictCount (MispredictCount)
   );

   // ---------------- reference model ----------------
   bit          m_valid [16];
   logic [7:0]  m_tag   [16];
   int          m_ctr   [16];
   logic [31:0] m_tgt   [16];
   bit          m_pred;
   logic [31:0] m_ptgt;
   int          m_pidx;
   logic [7:0]  m_ptag;
   int          m_bc;
   int          m_mc;

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) & 32'hF);
   endfunction

   function automatic logic [7:0] tag_of(input logic [31:0] pc);
      logic [31:0] t;
      t = (pc >> 6) & 32'hFF;
      return t[7:0];
   endfunction

   function automatic bit exp_taken_f();
      int i;
      i = idx_of(PCF);
      return m_valid[i] && (m_tag[i] == tag_of(PCF)) && (m_ctr[i] >= 2);
   endfunction

   function automatic logic [31:0] exp_target_f();
      return exp_taken_f() ? m_tgt[idx_of(PCF)] : PCF + 32'd4;
   endfunction

   function automatic bit exp_mis();
      return BranchD && ((BranchTakenD != m_pred) ||
             (m_pred && BranchTakenD && (m_ptgt != BranchTargetD)));
   endfunction

   // Advance the model by one clock using the current inputs, then wait for
   // the DUT edge and step 1 time unit past it.
   task automatic tick();
      bit          tf;
      logic [31:0] tt;
      bit          mis;
      int          di;
      tf  = exp_taken_f();
      tt  = exp_target_f();
      mis = exp_mis();
      if (reset) begin
         for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 1;
         end
         m_pred = 0; m_ptgt = '0; m_pidx = 0; m_ptag = '0;
         m_bc = 0; m_mc = 0;
      end else begin
         if (BranchD && !StallD) begin
            di = m_pidx;
            if (m_valid[di] && (m_tag[di] == m_ptag)) begin
               if (BranchTakenD) begin
                  m_ctr[di] = (m_ctr[di] >= 3) ? 3 : m_ctr[di] + 1;
                  m_tgt[di] = BranchTargetD;
               end else begin
                  m_ctr[di] = (m_ctr[di] <= 0) ? 0 : m_ctr[di] - 1;
               end
            end else if (BranchTakenD) begin
               m_valid[di] = 1;
               m_tag[di]   = m_ptag;
               m_ctr[di]   = 2;
               m_tgt[di]   = BranchTargetD;
            end
            if (m_bc < 65535) m_bc++;
            if (mis && (m_mc < 65535)) m_mc++;
         end
         if (FlushD) begin
            m_pred = 0; m_ptgt = '0; m_pidx = 0; m_ptag = '0;
         end else if (!StallD) begin
            m_pred = tf; m_ptgt = tt; m_pidx = idx_of(PCF); m_ptag = tag_of(PCF);
         end
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic apply_reset();
      reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
      BranchD = 1'b0; BranchTakenD = 1'b0; BranchTargetD = '0; PCF = 32'h100;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Fetch pc for one cycle, then resolve it in decode while fetch re-reads pc.
   task automatic run_branch(input logic [31:0] pc, input bit taken, input logic [31:0] tgt,
                             output logic obs_mis, output logic obs_tf);
      StallD = 1'b0; FlushD = 1'b0; BranchD = 1'b0; PCF = pc;
      #1;
      tick();
      BranchD = 1'b1; BranchTakenD = taken; BranchTargetD = tgt; PCF = pc;
      #1;
      obs_mis = MispredictD;
      obs_tf  = PredictTakenF;
      tick();
      BranchD = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      apply_reset();
      PCF = 32'h100;
      #1;
      tick();                       // D now holds index 0 / tag 4
      reset = 1'b1; BranchD = 1'b1; BranchTakenD = 1'b1; BranchTargetD = 32'h999;
      tick();
      tick();
      reset = 1'b0; BranchD = 1'b0; PCF = 32'h100;
      #1;
      n_checks++;
      if (PredictTakenF !== 1'b0) begin n_errors++; $display("FAIL reset_taken got=%b exp=0", PredictTakenF); end
      n_checks++;
      if (PredictTargetF !== 32'h104) begin n_errors++; $display("FAIL reset_target got=%h exp=00000104", PredictTargetF); end
      n_checks++;
      if (Prediction !== 1'b0) begin n_errors++; $display("FAIL reset_prediction got=%b exp=0", Prediction); end
      n_checks++;
      if (MispredictD !== 1'b0) begin n_errors++; $display("FAIL reset_mispredict got=%b exp=0", MispredictD); end
      n_checks++;
      if (BranchCount !== 16'd0) begin n_errors++; $display("FAIL reset_branch_cnt got=%0d exp=0", BranchCount); end
      n_checks++;
      if (MispredictCount !== 16'd0) begin n_errors++; $display("FAIL reset_mis_cnt got=%0d exp=0", MispredictCount); end
   endtask

   task automatic test_allocate();
      logic mis, tf;
      apply_reset();
      run_branch(32'h100, 1'b1, 32'h200, mis, tf);
      n_checks++;
      if (mis !== 1'b1) begin n_errors++; $display("FAIL alloc_mispredict got=%b exp=1", mis); end
      n_checks++;
      if (tf !== 1'b0) begin n_errors++; $display("FAIL alloc_no_bypass got=%b exp=0", tf); end
      PCF = 32'h100;
      #1;
      n_checks++;
      if (PredictTakenF !== 1'b1) begin n_errors++; $display("FAIL alloc_taken got=%b exp=1", PredictTakenF); end
      n_checks++;
      if (PredictTargetF !== 32'h200) begin n_errors++; $display("FAIL alloc_target got=%h exp=00000200", PredictTargetF); end
      n_checks++;
      if ((BranchCount !== 16'd1) || (MispredictCount !== 16'd1)) begin
         n_errors++; $display("FAIL alloc_counts got=%0d/%0d exp=1/1", BranchCount, MispredictCount);
      end
   endtask

   task automatic test_counter_saturate();
      logic mis, tf;
      apply_reset();
      run_branch(32'h100, 1'b1, 32'h200, mis, tf);
      for (int k = 0; k < 3; k++) begin
         run_branch(32'h100, 1'b1, 32'h200, mis, tf);
         n_checks++;
         if (mis !== 1'b0) begin n_errors++; $display("FAIL sat_taken_%0d mispredict got=%b exp=0", k, mis); end
      end
      run_branch(32'h100, 1'b0, 32'h200, mis, tf);
      n_checks++;
      if (mis !== 1'b1) begin n_errors++; $display("FAIL sat_nt1_mispredict got=%b exp=1", mis); end
      PCF = 32'h100;
      #1;
      n_checks++;
      if (PredictTakenF !== 1'b1) begin n_errors++; $display("FAIL sat_after_nt1 got=%b exp=1", PredictTakenF); end
      run_branch(32'h100, 1'b0, 32'h200, mis, tf);
      n_checks++;
      if (mis !== 1'b1) begin n_errors++; $display("FAIL sat_nt2_mispredict got=%b exp=1", mis); end
      PCF = 32'h100;
      #1;
      n_checks++;
      if ((PredictTakenF !== 1'b0) || (PredictTargetF !== 32'h104)) begin
         n_errors++; $display("FAIL sat_after_nt2 got=%b/%h exp=0/00000104", PredictTakenF, PredictTargetF);
      end
      n_checks++;
      if ((BranchCount !== 16'd6) || (MispredictCount !== 16'd3)) begin
         n_errors++; $display("FAIL sat_counts got=%0d/%0d exp=6/3", BranchCount, MispredictCount);
      end
   endtask

   task automatic test_target_change();
      logic mis, tf;
      apply_reset();
      run_branch(32'h100, 1'b1, 32'h200, mis, tf);
      run_branch(32'h100, 1'b1, 32'h300, mis, tf);
      n_checks++;
      if (mis !== 1'b1) begin n_errors++; $display("FAIL tgt_mispredict got=%b exp=1", mis); end
      PCF = 32'h100;
      #1;
      n_checks++;
      if ((PredictTakenF !== 1'b1) || (PredictTargetF !== 32'h300)) begin
         n_errors++; $display("FAIL tgt_updated got=%b/%h exp=1/00000300", PredictTakenF, PredictTargetF);
      end
   endtask

   task automatic test_stall_flush();
      logic mis, tf;
      apply_reset();
      run_branch(32'h100, 1'b1, 32'h200, mis, tf);
      PCF = 32'h100;
      #1;
      tick();                                   // Prediction = 1 for 0x100
      BranchD = 1'b1; BranchTakenD = 1'b0; StallD = 1'b1; PCF = 32'h500;
      for (int k = 0; k < 2; k++) begin
         #1;
         n_checks++;
         if (Prediction !== 1'b1) begin n_errors++; $display("FAIL stall_hold_%0d got=%b exp=1", k, Prediction); end
         n_checks++;
         if (MispredictD !== 1'b1) begin n_errors++; $display("FAIL stall_mis_%0d got=%b exp=1", k, MispredictD); end
         tick();
      end
      n_checks++;
      if ((BranchCount !== 16'd1) || (MispredictCount !== 16'd1)) begin
         n_errors++; $display("FAIL stall_counts got=%0d/%0d exp=1/1", BranchCount, MispredictCount);
      end
      BranchD = 1'b0; StallD = 1'b0; PCF = 32'h100;
      #1;
      n_checks++;
      if (PredictTakenF !== 1'b1) begin n_errors++; $display("FAIL stall_no_write got=%b exp=1", PredictTakenF); end
      FlushD = 1'b1; StallD = 1'b1;
      tick();
      FlushD = 1'b0; StallD = 1'b0;
      n_checks++;
      if (Prediction !== 1'b0) begin n_errors++; $display("FAIL flush_clear got=%b exp=0", Prediction); end
   endtask

   task automatic test_alias();
      logic mis, tf;
      apply_reset();
      run_branch(32'h100, 1'b1, 32'h200, mis, tf);
      PCF = 32'h140;
      #1;
      n_checks++;
      if ((PredictTakenF !== 1'b0) || (PredictTargetF !== 32'h144)) begin
         n_errors++; $display("FAIL alias_miss got=%b/%h exp=0/00000144", PredictTakenF, PredictTargetF);
      end
      run_branch(32'h140, 1'b0, 32'h600, mis, tf);
      n_checks++;
      if (mis !== 1'b0) begin n_errors++; $display("FAIL alias_nt_mis got=%b exp=0", mis); end
      PCF = 32'h100;
      #1;
      n_checks++;
      if ((PredictTakenF !== 1'b1) || (PredictTargetF !== 32'h200)) begin
         n_errors++; $display("FAIL alias_keep got=%b/%h exp=1/00000200", PredictTakenF, PredictTargetF);
      end
      run_branch(32'h140, 1'b1, 32'h600, mis, tf);
      n_checks++;
      if (mis !== 1'b1) begin n_errors++; $display("FAIL alias_t_mis got=%b exp=1", mis); end
      PCF = 32'h140;
      #1;
      n_checks++;
      if ((PredictTakenF !== 1'b1) || (PredictTargetF !== 32'h600)) begin
         n_errors++; $display("FAIL alias_alloc got=%b/%h exp=1/00000600", PredictTakenF, PredictTargetF);
      end
      PCF = 32'h100;
      #1;
      n_checks++;
      if ((PredictTakenF !== 1'b0) || (PredictTargetF !== 32'h104)) begin
         n_errors++; $display("FAIL alias_replaced got=%b/%h exp=0/00000104", PredictTakenF, PredictTargetF);
      end
   endtask

   task automatic test_random();
      logic [31:0] pc_pool  [6];
      logic [31:0] tgt_pool [4];
      pc_pool  = '{32'h100, 32'h140, 32'h180, 32'h104, 32'h144, 32'h2100};
      tgt_pool = '{32'h200, 32'h300, 32'h400, 32'h1000};
      apply_reset();
      for (int n = 0; n < 400; n++) begin
         PCF           = pc_pool[$urandom_range(0, 5)];
         BranchD       = ($urandom_range(0, 1) == 1);
         BranchTakenD  = ($urandom_range(0, 2) != 0);
         BranchTargetD = tgt_pool[$urandom_range(0, 3)];
         StallD        = ($urandom_range(0, 4) == 0);
         FlushD        = ($urandom_range(0, 9) == 0);
         StallF        = ($urandom_range(0, 1) == 1);
         reset         = ($urandom_range(0, 99) == 0);
         #1;
         n_checks++;
         if (PredictTakenF !== exp_taken_f()) begin
            n_errors++; $display("FAIL rnd_taken n=%0d got=%b exp=%b", n, PredictTakenF, exp_taken_f());
         end
         n_checks++;
         if (PredictTargetF !== exp_target_f()) begin
            n_errors++; $display("FAIL rnd_target n=%0d got=%h exp=%h", n, PredictTargetF, exp_target_f());
         end
         n_checks++;
         if (Prediction !== m_pred) begin
            n_errors++; $display("FAIL rnd_prediction n=%0d got=%b exp=%b", n, Prediction, m_pred);
         end
         n_checks++;
         if (MispredictD !== exp_mis()) begin
            n_errors++; $display("FAIL rnd_mispredict n=%0d got=%b exp=%b", n, MispredictD, exp_mis());
         end
         n_checks++;
         if ((BranchCount !== 16'(m_bc)) || (MispredictCount !== 16'(m_mc))) begin
            n_errors++; $display("FAIL rnd_counts n=%0d got=%0d/%0d exp=%0d/%0d", n, BranchCount, MispredictCount, m_bc, m_mc);
         end
         tick();
      end
      reset = 1'b0; StallF = 1'b0;
   endtask

   task automatic test_perf_saturate();
      apply_reset();
      BranchD = 1'b1; StallD = 1'b0; FlushD = 1'b0; PCF = 32'h100; BranchTargetD = 32'h200;
      for (int n = 0; n < 65535; n++) begin
         BranchTakenD = ($urandom_range(0, 1) == 1);
         tick();
      end
      n_checks++;
      if (BranchCount !== 16'hFFFF) begin n_errors++; $display("FAIL perf_reach_max got=%h exp=ffff", BranchCount); end
      for (int n = 0; n < 5; n++) begin
         BranchTakenD = ($urandom_range(0, 1) == 1);
         tick();
      end
      BranchD = 1'b0;
      n_checks++;
      if (BranchCount !== 16'hFFFF) begin n_errors++; $display("FAIL perf_hold_max got=%h exp=ffff", BranchCount); end
      n_checks++;
      if (MispredictCount !== 16'(m_mc)) begin
         n_errors++; $display("FAIL perf_mis_cnt got=%0d exp=%0d", MispredictCount, m_mc);
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      reset = 1'b1; PCF = 32'h100; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
      BranchD = 1'b0; BranchTakenD = 1'b0; BranchTargetD = '0;
      test_reset();
      test_allocate();
      test_counter_saturate();
      test_target_change();
      test_stall_flush();
      test_alias();
      test_random();
      test_perf_saturate();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 4, log2 of table entries (16).
REQ-002 SHALL have parameter TAG_BITS, default 8, stored PC tag width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset is synchronous and active-high.
REQ-005 SHALL have port PCF  input  32  fetch-stage PC.
REQ-006 SHALL have port StallF  input  1  fetch stall (informational; prediction still combinational).
REQ-007 SHALL have port StallD  input  1  hold F->D prediction register.
REQ-008 SHALL have port FlushD  input  1  clear F->D prediction register.
REQ-009 SHALL have port BranchD  input  1  valid branch instruction in decode.
REQ-010 SHALL have port BranchTakenD  input  1  resolved branch direction in decode.
REQ-011 SHALL have port BranchTargetD  input  32  resolved branch target in decode.
REQ-012 SHALL have port PredictTakenF  output  1  fetch redirect request.
REQ-013 SHALL have port PredictTargetF  output  32  predicted next PC.
REQ-014 SHALL have port Prediction  output  1  registered prediction of decode instruction, feeds hazard unit.
REQ-015 SHALL have port MispredictD  output  1  direction or target mismatch in decode.
REQ-016 SHALL have ports BranchCount, MispredictCount  output  16 each  performance counters.

Function
REQ-017 SHALL compute index = PCF[INDEX_BITS+1:2], tag = PCF[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2].
REQ-018 SHALL hold per entry: valid, tag, 2-bit counter, 32-bit target.
REQ-019 SHALL assert hit = valid[index] & (tag == stored tag), combinationally, zero latency.
REQ-020 SHALL drive PredictTakenF = hit & counter[1]; PredictTargetF = stored target when PredictTakenF, else PCF+4.
REQ-021 SHALL register F->D: Prediction, predicted target, index, tag; FlushD clears Prediction to 0 (FlushD wins over StallD); StallD holds; otherwise load.
REQ-022 SHALL drive MispredictD = BranchD & ((BranchTakenD ^ Prediction) | (Prediction & BranchTakenD & (predicted target != BranchTargetD))).
REQ-023 SHALL update tables when BranchD & ~StallD, using D-stage index/tag, one update per cycle.
REQ-024 On tag hit: counter saturating +1 if taken (max 2'b11), -1 if not taken (min 2'b00); target rewritten with BranchTargetD if taken.
REQ-025 On tag miss and taken: allocate: valid=1, tag written, counter=2'b10, target=BranchTargetD; miss and not taken: no write.
REQ-026 Same-cycle read and write of one index SHALL return pre-update contents (no bypass).
REQ-027 BranchCount SHALL increment on each update; MispredictCount on each update with MispredictD=1; both saturate at 16'hFFFF.

Reset
REQ-028 reset SHALL clear all valid bits, set all counters to 2'b01, clear Prediction, predicted target, index/tag registers and both perf counters.
REQ-029 reset SHALL override StallD, FlushD and any same-cycle update.
REQ-030 After reset deassert, first cycle SHALL predict not-taken (PredictTakenF=0, PredictTargetF=PCF+4).

Structure
REQ-031 Shared package bp_pkg SHALL hold INDEX_BITS/TAG_BITS defaults and counter constants (SNT=00, WNT=01, WT=10, ST=11).
REQ-032 Storage SHALL be a sub-module bp_table (async read port, sync write port, sync reset of valid/counters); perf counters and F->D register stay in top.

Verification
REQ-033 Reset, PCF=0x100 -> PredictTakenF=0, PredictTargetF=0x104, Prediction=0, counters 0.
REQ-034 Branch at 0x100 taken to 0x200 (miss) -> MispredictD=1, entry allocated counter=10; next fetch 0x100 -> PredictTakenF=1, PredictTargetF=0x200.
REQ-035 Same branch taken 3x more -> counter 11, stays 11; then not taken once -> counter 10, still predicted taken, MispredictD=1.
REQ-036 Hit, taken, BranchTargetD=0x300 vs stored 0x200 -> MispredictD=1, target updated to 0x300.
REQ-037 BranchD=1 with StallD=1 for 2 cycles -> no table write, counters unchanged, Prediction held; FlushD=1 -> Prediction=0.
REQ-038 Aliasing PCs 0x100 and 0x140 (INDEX_BITS=4, same index, different tag) -> 0x140 misses until allocated, then replaces 0x100 entry.
